rnn_mem_arb: RTL and testbench
==============================

RNN_MEM_ARB -- requirements
Module: rnn_mem_arb

Interface
REQ-001 SHALL have parameter MAX_BURST, 64, maximum consecutive locked grants to one requester while the other waits.
REQ-002 SHALL have parameter AW, 17, memory address width.
REQ-003 SHALL have parameter DW, 20, memory data width.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rN_req  in  1  (N=0,1) requester N wants one memory access this cycle.
REQ-007 rN_lock  in  1  requester N asks to keep ownership for the next cycle (burst).
REQ-008 rN_msel  in  3  requester N memory select code.
REQ-009 rN_maddr  in  AW  requester N address.
REQ-010 rN_wdata  in  DW  requester N write data.
REQ-011 rN_gnt  out  1  access of requester N is issued this cycle.
REQ-012 rN_rvalid  out  1  read data for requester N is present this cycle.
REQ-013 rN_rdata  out  DW  read data for requester N.
REQ-014 mce  out  1  memory chip enable.
REQ-015 msel  out  3  memory select to shared memory.
REQ-016 maddr  out  AW  address to shared memory.
REQ-017 mdata_w  out  DW  write data to shared memory.
REQ-018 mdata_r  in  DW  read data from shared memory, valid one cycle after its access.

Function
REQ-019 SHALL grant at most one requester per cycle; rN_gnt combinational from rN_req and registered state.
REQ-020 SHALL grant the current owner if owner_req & owner_lock and (burst_cnt < MAX_BURST or other requester idle).
REQ-021 Otherwise SHALL grant round-robin: the requester not granted last wins if requesting, else the other requester if requesting, else none.
REQ-022 On a grant SHALL drive msel/maddr/mdata_w from the granted requester and mce=1 in the same cycle; with no grant mce=0, msel/maddr/mdata_w=0.
REQ-023 Owner register SHALL update each cycle to the granted requester if its rN_lock=1, else to NONE.
REQ-024 burst_cnt SHALL load 1 on a grant to a new owner, increment (saturating at MAX_BURST) on a continued grant, clear to 0 on no grant.
REQ-025 Forced handover at burst_cnt=MAX_BURST with other requester waiting SHALL grant the other requester that same cycle; the preempted requester re-arbitrates normally.
REQ-026 An access with msel=3'b101 (hidden-state output region) SHALL be a write; all other codes SHALL be reads.
REQ-027 For a granted read SHALL assert rN_rvalid of that requester exactly one cycle later with rN_rdata=mdata_r; writes SHALL produce no rvalid.
REQ-028 rN_rdata SHALL be 0 whenever rN_rvalid=0.
REQ-029 Owner dropping rN_req mid-burst SHALL release ownership that cycle; other requester may be granted in the same cycle.
REQ-030 rN_lock without rN_req SHALL have no effect.
REQ-031 Back-to-back grants to alternating requesters SHALL be allowed with zero idle cycles; read returns pipeline without loss.

Reset
REQ-032 While reset=1: all rN_gnt=0, mce=0, msel=0, maddr=0, mdata_w=0, rN_rvalid=0, rN_rdata=0.
REQ-033 Reset SHALL set owner=NONE, burst_cnt=0, last-granted=1 (requester 0 wins the first contested cycle).
REQ-034 Reset asserted mid-burst SHALL drop ownership; any read issued in the cycle before reset SHALL NOT produce rvalid in the reset cycle.

Structure
REQ-035 Shared package rnn_mem_pkg SHALL hold msel codes (WX=000, BX=001, WH=010, BH=011, LEN=100, HOUT=101), AW/DW defaults and owner encoding.
REQ-036 Round-robin pick logic SHALL be one sub-module rnn_rr_pick2 (inputs req[1:0], last; output gnt[1:0]).

Verification
REQ-037 Reset release, r0_req=r1_req=1 unlocked for 4 cycles -> grants 0,1,0,1; mce=1 every cycle.
REQ-038 r0 read msel=000 maddr=0x00005, mdata_r=0x12345 next cycle -> r0_rvalid=1, r0_rdata=0x12345 in that cycle only; r1_rvalid=0.
REQ-039 MAX_BURST=4, r0 req+lock held, r1_req=1 from cycle 1 -> r0 granted 4 cycles, r1 granted 5th cycle.
REQ-040 r1 write msel=101 maddr=0x00FC1 wdata=0x10000 -> msel=101, maddr=0x00FC1, mdata_w=0x10000, mce=1 that cycle; no r1_rvalid next cycle.
REQ-041 r0 locked burst, reset=1 on 3rd cycle -> gnt/mce/rvalid 0 during reset; after release with both requesting, r0 granted first.
REQ-042 Owner r1 drops req mid-lock while r0_req=1 -> r0 granted same cycle, no idle gap.

Source files
------------

// File: rtl/rnn_mem_pkg.sv
// Shared definitions for the RNN memory arbiter: memory select codes,
// default bus widths and the burst-owner encoding.
package rnn_mem_pkg;

  localparam int AW_DEF = 17;
  localparam int DW_DEF = 20;

  typedef enum logic [2:0] {
    MSEL_WX   = 3'b000,
    MSEL_BX   = 3'b001,
    MSEL_WH   = 3'b010,
    MSEL_BH   = 3'b011,
    MSEL_LEN  = 3'b100,
    MSEL_HOUT = 3'b101
  } msel_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_R0   = 2'b01,
    OWN_R1   = 2'b10
  } owner_e;

  // Only the hidden-state output region is written; every other region is read.
  function automatic logic is_write(input logic [2:0] code);
    return (code == MSEL_HOUT);
  endfunction

endpackage

// File: rtl/rnn_rr_pick2.sv
// Two-way round-robin picker: the requester that was not granted last wins.
module rnn_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Fairness pick between the two requesters
  always_comb begin
    gnt = 2'b00;
    if (last) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
      else             gnt = 2'b00;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
      else             gnt = 2'b00;
    end
  end

endmodule

// File: rtl/rnn_mem_arb.sv
// Two-requester shared-memory arbiter with locked bursts bounded by MAX_BURST,
// same-cycle grant/command issue and one-cycle read-data return.
module rnn_mem_arb
  import rnn_mem_pkg::*;
#(
  parameter int MAX_BURST = 64,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_lock,
  input  logic [2:0]    r0_msel,
  input  logic [AW-1:0] r0_maddr,
  input  logic [DW-1:0] r0_wdata,
  input  logic          r1_req,
  input  logic          r1_lock,
  input  logic [2:0]    r1_msel,
  input  logic [AW-1:0] r1_maddr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          mce,
  output logic [2:0]    msel,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mdata_w,
  input  logic [DW-1:0] mdata_r
);

  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]    req_s;
  logic [1:0]    lock_s;
  logic [1:0]    rr_gnt_s;
  logic [1:0]    hold_gnt_s;
  logic [1:0]    gnt_s;
  logic          below_max_s;
  logic          cont_s;
  owner_e        owner_r;
  logic [CW-1:0] burst_cnt_r;
  logic          last_r;
  logic [1:0]    rvalid_r;

  assign req_s       = {r1_req, r0_req};
  assign lock_s      = {r1_lock, r0_lock};
  assign below_max_s = (burst_cnt_r < MAX_CNT);

  rnn_rr_pick2 u_pick (
    .req  (req_s),
    .last (last_r),
    .gnt  (rr_gnt_s)
  );

  // Grant selection: a locked owner keeps the bus until its burst budget runs out
  // while the other side waits; otherwise fall back to round-robin.
  always_comb begin
    hold_gnt_s = 2'b00;
    case (owner_r)
      OWN_R0: begin
        if (req_s[0] && lock_s[0] && (below_max_s || !req_s[1])) hold_gnt_s = 2'b01;
        else                                                     hold_gnt_s = 2'b00;
      end
      OWN_R1: begin
        if (req_s[1] && lock_s[1] && (below_max_s || !req_s[0])) hold_gnt_s = 2'b10;
        else                                                     hold_gnt_s = 2'b00;
      end
      default: hold_gnt_s = 2'b00;
    endcase
    if (reset)                      gnt_s = 2'b00;
    else if (hold_gnt_s != 2'b00)   gnt_s = hold_gnt_s;
    else                            gnt_s = rr_gnt_s;
  end

  // Memory command mux from the granted requester
  always_comb begin
    mce     = 1'b0;
    msel    = 3'b000;
    maddr   = {AW{1'b0}};
    mdata_w = {DW{1'b0}};
    if (gnt_s[0]) begin
      mce     = 1'b1;
      msel    = r0_msel;
      maddr   = r0_maddr;
      mdata_w = r0_wdata;
    end else if (gnt_s[1]) begin
      mce     = 1'b1;
      msel    = r1_msel;
      maddr   = r1_maddr;
      mdata_w = r1_wdata;
    end else begin
      mce     = 1'b0;
    end
  end

  assign r0_gnt = gnt_s[0];
  assign r1_gnt = gnt_s[1];
  assign cont_s = ((owner_r == OWN_R0) && gnt_s[0]) || ((owner_r == OWN_R1) && gnt_s[1]);

  // Ownership, burst length, fairness pointer and read-return tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r     <= OWN_NONE;
      burst_cnt_r <= {CW{1'b0}};
      last_r      <= 1'b1;
      rvalid_r    <= 2'b00;
    end else begin
      if (gnt_s != 2'b00) begin
        last_r <= gnt_s[1];
        if (cont_s) begin
          if (burst_cnt_r == MAX_CNT) burst_cnt_r <= burst_cnt_r;
          else                        burst_cnt_r <= burst_cnt_r + CNT_ONE;
        end else begin
          burst_cnt_r <= CNT_ONE;
        end
        if ((gnt_s & lock_s) != 2'b00) owner_r <= gnt_s[1] ? OWN_R1 : OWN_R0;
        else                           owner_r <= OWN_NONE;
      end else begin
        burst_cnt_r <= {CW{1'b0}};
        owner_r     <= OWN_NONE;
      end
      rvalid_r <= gnt_s & {2{~is_write(msel)}};
    end
  end

  // Read returns are masked during reset so a read issued just before reset is dropped.
  assign r0_rvalid = rvalid_r[0] & ~reset;
  assign r1_rvalid = rvalid_r[1] & ~reset;
  assign r0_rdata  = r0_rvalid ? mdata_r : {DW{1'b0}};
  assign r1_rdata  = r1_rvalid ? mdata_r : {DW{1'b0}};

endmodule

// File: tb/tb_rnn_mem_arb.sv
// Directed plus randomized bench for rnn_mem_arb against a cycle-level reference model.
module tb_rnn_mem_arb;

  localparam int MAXB = 4;
  localparam int AW   = 17;
  localparam int DW   = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [1:0]          req;
  logic [1:0]          lock;
  logic [1:0][2:0]     msel_i;
  logic [1:0][AW-1:0]  maddr_i;
  logic [1:0][DW-1:0]  wdata_i;
  logic [DW-1:0]       mdata_r;

  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mce;
  logic [DW-1:0] r0_rdata, r1_rdata, mdata_w;
  logic [2:0]    msel;
  logic [AW-1:0] maddr;

  int checks   = 0;
  int failures = 0;

  // reference model state: -1 means none
  int m_owner = -1;
  int m_run   = 0;
  int m_last  = 1;
  int m_pend  = -1;
  int m_g     = -1;

  rnn_mem_arb #(.MAX_BURST(MAXB), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .r0_req(req[0]), .r0_lock(lock[0]), .r0_msel(msel_i[0]), .r0_maddr(maddr_i[0]), .r0_wdata(wdata_i[0]),
    .r1_req(req[1]), .r1_lock(lock[1]), .r1_msel(msel_i[1]), .r1_maddr(maddr_i[1]), .r1_wdata(wdata_i[1]),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mce(mce), .msel(msel), .maddr(maddr), .mdata_w(mdata_w), .mdata_r(mdata_r)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int predict();
    int p;
    if (reset) return -1;
    if (m_owner >= 0 && req[m_owner] && lock[m_owner] && (m_run < MAXB || !req[1 - m_owner]))
      return m_owner;
    p = 1 - m_last;
    if (req[p]) return p;
    if (req[1 - p]) return 1 - p;
    return -1;
  endfunction

  // called at posedge+1 with inputs already applied; samples before the next posedge
  task automatic eval_cycle();
    logic [2:0]    e_msel;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_rv0, e_rv1;
    #3;
    m_g    = predict();
    e_msel = 3'b000;
    e_addr = '0;
    e_wd   = '0;
    if (m_g >= 0) begin
      e_msel = msel_i[m_g];
      e_addr = maddr_i[m_g];
      e_wd   = wdata_i[m_g];
    end
    e_rv0 = !reset && (m_pend == 0);
    e_rv1 = !reset && (m_pend == 1);
    chk("r0_gnt", r0_gnt, m_g == 0);
    chk("r1_gnt", r1_gnt, m_g == 1);
    chk("mce", mce, m_g >= 0);
    chk("msel", msel, e_msel);
    chk("maddr", maddr, e_addr);
    chk("mdata_w", mdata_w, e_wd);
    chk("r0_rvalid", r0_rvalid, e_rv0);
    chk("r1_rvalid", r1_rvalid, e_rv1);
    chk("r0_rdata", r0_rdata, e_rv0 ? mdata_r : '0);
    chk("r1_rdata", r1_rdata, e_rv1 ? mdata_r : '0);
  endtask

  task automatic adv();
    @(posedge clk);
    if (reset) begin
      m_owner = -1; m_run = 0; m_last = 1; m_pend = -1;
    end else if (m_g >= 0) begin
      m_run   = (m_g == m_owner) ? ((m_run < MAXB) ? m_run + 1 : MAXB) : 1;
      m_owner = lock[m_g] ? m_g : -1;
      m_last  = m_g;
      m_pend  = (msel_i[m_g] == 3'b101) ? -1 : m_g;
    end else begin
      m_run = 0; m_owner = -1; m_pend = -1;
    end
    #1;
  endtask

  task automatic step(input bit use_want, input logic [1:0] want);
    eval_cycle();
    if (use_want) chk("want_gnt", {r1_gnt, r0_gnt}, want);
    adv();
  endtask

  initial begin
    reset = 1'b1; req = 2'b11; lock = 2'b00; mdata_r = '0;
    msel_i = '0; maddr_i = '0; wdata_i = '0;
    @(posedge clk); #1;
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);

    // both unlocked: strict alternation starting with r0
    reset = 1'b0; req = 2'b11; lock = 2'b00;
    maddr_i[0] = 17'h00011; maddr_i[1] = 17'h00022;
    step(1'b1, 2'b01); step(1'b1, 2'b10); step(1'b1, 2'b01); step(1'b1, 2'b10);

    // single read by r0 and its data return
    req = 2'b01; msel_i[0] = 3'b000; maddr_i[0] = 17'h00005;
    step(1'b1, 2'b01);
    req = 2'b00; mdata_r = 20'h12345;
    eval_cycle();
    chk("rd_rvalid0", r0_rvalid, 1'b1);
    chk("rd_rdata0", r0_rdata, 20'h12345);
    chk("rd_rvalid1", r1_rvalid, 1'b0);
    adv();
    mdata_r = 20'h0ABCD;
    eval_cycle();
    chk("rd_rvalid0_once", r0_rvalid, 1'b0);
    adv();

    // burst bounded by MAX_BURST with r1 waiting
    req = 2'b01; lock = 2'b01; msel_i[0] = 3'b001;
    step(1'b1, 2'b01);
    req = 2'b11;
    step(1'b1, 2'b01); step(1'b1, 2'b01); step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    lock = 2'b00;
    step(1'b1, 2'b01);

    // write by r1: no read return
    req = 2'b10; lock = 2'b00;
    msel_i[1] = 3'b101; maddr_i[1] = 17'h00FC1; wdata_i[1] = 20'h10000;
    eval_cycle();
    chk("wr_msel", msel, 3'b101);
    chk("wr_maddr", maddr, 17'h00FC1);
    chk("wr_wdata", mdata_w, 20'h10000);
    chk("wr_mce", mce, 1'b1);
    adv();
    req = 2'b00;
    eval_cycle();
    chk("wr_no_rvalid", r1_rvalid, 1'b0);
    adv();

    // reset in the middle of a locked read burst
    req = 2'b01; lock = 2'b01; msel_i[0] = 3'b000;
    step(1'b1, 2'b01); step(1'b1, 2'b01);
    reset = 1'b1; req = 2'b11;
    eval_cycle();
    chk("rst_gnt", {r1_gnt, r0_gnt}, 2'b00);
    chk("rst_mce", mce, 1'b0);
    chk("rst_rvalid", r0_rvalid, 1'b0);
    adv();
    reset = 1'b0; lock = 2'b00;
    step(1'b1, 2'b01);

    // owner r1 drops its request mid-lock
    req = 2'b10; lock = 2'b10; msel_i[1] = 3'b010;
    step(1'b1, 2'b10); step(1'b1, 2'b10);
    req = 2'b01; lock = 2'b00;
    step(1'b1, 2'b01);

    // lone locked owner keeps the bus past MAX_BURST, then yields when r1 shows up
    req = 2'b01; lock = 2'b01;
    for (int i = 0; i < 6; i++) step(1'b1, 2'b01);
    req = 2'b11;
    step(1'b1, 2'b10);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(49) == 0);
      req     = 2'($urandom);
      lock    = 2'($urandom);
      mdata_r = DW'($urandom);
      for (int k = 0; k < 2; k++) begin
        msel_i[k]  = 3'($urandom_range(7));
        maddr_i[k] = AW'($urandom);
        wdata_i[k] = DW'($urandom);
      end
      step(1'b0, 2'b00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
